// File: rtl/adam_apb_mst_pkg.sv
// Shared types for the APB4 requester: bus-width config, FSM state and response payload.
//   ADAM_ADDR_WIDTH / ADAM_DATA_WIDTH : default bus widths used by ADAM peripherals
//   ADDR_T / DATA_T / STRB_T          : bus field types at those widths
//   apb_mst_state_e                   : requester FSM states
//   apb_mst_rsp_t                     : captured response {rdata, err}
package adam_apb_mst_pkg;

    localparam int unsigned ADAM_ADDR_WIDTH = 32;
    localparam int unsigned ADAM_DATA_WIDTH = 32;
    localparam int unsigned ADAM_STRB_WIDTH = ADAM_DATA_WIDTH / 8;

    typedef logic [ADAM_ADDR_WIDTH-1:0] ADDR_T;
    typedef logic [ADAM_DATA_WIDTH-1:0] DATA_T;
    typedef logic [ADAM_STRB_WIDTH-1:0] STRB_T;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_PAUSED = 3'd4
    } apb_mst_state_e;

    typedef struct packed {
        DATA_T rdata;
        logic  err;
    } apb_mst_rsp_t;

endpackage

// File: rtl/adam_apb_mst_if.sv
// APB4 bus bundle between a requester and a completer.
//   master modport : drives paddr/pprot/psel/penable/pwrite/pwdata/pstrb,
//                    samples pready/prdata/pslverr
//   slave modport  : the mirror image
interface adam_apb_mst_if
    import adam_apb_mst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ADAM_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/adam_apb_mst.sv
// APB4 requester: converts a valid/ready request channel into single APB
// transfers and returns {rdata, err} on a valid/ready response channel.
// Drains any in-flight transfer before acknowledging a pause, and aborts an
// ACCESS phase that exceeds TIMEOUT wait cycles (0 disables the abort).
//   clk_i, rst_i             : clock, synchronous active-high reset
//   pause_req_i / pause_ack_o: pause handshake
//   req_*                    : request channel (req_ready_o is combinational)
//   rsp_*                    : response channel
//   mst                      : APB master port
module adam_apb_mst
    import adam_apb_mst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ADAM_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      pause_req_i,
    output logic                      pause_ack_o,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic                      req_write_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   req_strb_i,
    input  logic [2:0]                req_prot_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_err_o,

    adam_apb_mst_if.master            mst
);

    // A zero TIMEOUT still gets a 1-bit counter so the logic stays legal.
    localparam int unsigned CNT_WIDTH = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT);

    apb_mst_state_e              state_q;
    logic [ADDR_WIDTH-1:0]       paddr_q;
    logic [2:0]                  pprot_q;
    logic                        psel_q;
    logic                        penable_q;
    logic                        pwrite_q;
    logic [DATA_WIDTH-1:0]       pwdata_q;
    logic [DATA_WIDTH/8-1:0]     pstrb_q;
    logic                        rsp_valid_q;
    apb_mst_rsp_t                rsp_q;
    logic                        pause_ack_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [CNT_WIDTH-1:0]        cnt_d;
    logic                        timeout_c;

    // Wait counter increment, saturating at TIMEOUT.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // Abort when this wait cycle brings the count to TIMEOUT; pready in the
    // same cycle is checked first and therefore wins.
    assign timeout_c = (TIMEOUT != 0) && (cnt_d == CNT_MAX);

    // Ready only in IDLE with no pause pending; held low while reset is applied.
    assign req_ready_o = (state_q == ST_IDLE) && !pause_req_i && !rst_i;

    // FSM, request capture, response capture and wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pprot_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            pause_ack_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pause_req_i) begin
                        pause_ack_q <= 1'b1;
                        state_q     <= ST_PAUSED;
                    end else if (req_valid_i) begin
                        // Reads never expose write data or strobes on the bus.
                        paddr_q  <= req_addr_i;
                        pprot_q  <= req_prot_i;
                        pwrite_q <= req_write_i;
                        pwdata_q <= req_write_i ? req_wdata_i : '0;
                        pstrb_q  <= req_write_i ? req_strb_i  : '0;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (mst.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_q.rdata <= (pwrite_q || mst.pslverr) ? '0
                                                                 : ADAM_DATA_WIDTH'(mst.prdata);
                        rsp_q.err   <= mst.pslverr;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (timeout_c) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_q.rdata <= '0;
                        rsp_q.err   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                // Pause is deliberately not looked at until the response drains.
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_PAUSED: begin
                    if (!pause_req_i) begin
                        pause_ack_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mst.paddr   = paddr_q;
    assign mst.pprot   = pprot_q;
    assign mst.psel    = psel_q;
    assign mst.penable = penable_q;
    assign mst.pwrite  = pwrite_q;
    assign mst.pwdata  = pwdata_q;
    assign mst.pstrb   = pstrb_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = DATA_WIDTH'(rsp_q.rdata);
    assign rsp_err_o   = rsp_q.err;
    assign pause_ack_o = pause_ack_q;

endmodule

// File: tb/tb_adam_apb_mst.sv
// Bench for adam_apb_mst (TIMEOUT = 8): a directed vector table, hand-written
// pause and reset sequences, then randomized transfers predicted by a
// word-memory model of the completer.
module tb_adam_apb_mst;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst;
    logic        pause_req;
    logic        pause_ack;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    adam_apb_mst_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    adam_apb_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pause_req_i (pause_req),
        .pause_ack_o (pause_ack),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .req_prot_i  (req_prot),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mst         (apb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] mem_init(input int i);
        return (i == 0) ? 32'h1234_5678 : (32'h0BAD_0000 | 32'(i));
    endfunction

    // Completer: 16-word memory at paddr[5:2]; region paddr[7:6]==3 errors.
    logic [31:0] slv_mem [16];
    int unsigned slv_cnt;
    int unsigned cur_wait;
    logic        slv_hang;
    logic        slv_force_err;
    logic        slv_err_c;

    assign slv_err_c   = slv_force_err || (apb.paddr[7:6] == 2'b11);
    assign apb.pready  = apb.psel && apb.penable && !slv_hang && (slv_cnt == cur_wait);
    assign apb.pslverr = apb.pready && slv_err_c;
    assign apb.prdata  = slv_err_c ? 32'hDEAD_BEEF : slv_mem[apb.paddr[5:2]];

    always @(posedge clk) begin
        if (rst) begin
            slv_cnt <= 0;
            for (int i = 0; i < 16; i++) slv_mem[i] <= mem_init(i);
        end else begin
            if (apb.psel && apb.penable && !apb.pready) slv_cnt <= slv_cnt + 1;
            else slv_cnt <= 0;
            if (apb.pready && apb.pwrite && !apb.pslverr)
                for (int b = 0; b < 4; b++)
                    if (apb.pstrb[b]) slv_mem[apb.paddr[5:2]][8*b +: 8] <= apb.pwdata[8*b +: 8];
        end
    end

    function automatic logic [127:0] all_outputs();
        return 128'({req_ready, rsp_valid, rsp_err, rsp_rdata, apb.psel, apb.penable, apb.pwrite,
                     apb.paddr, apb.pwdata, apb.pstrb, apb.pprot, pause_ack});
    endfunction

    // One complete transfer, started at posedge+1 and ending one cycle after the response handshake.
    task automatic do_xfer(input string nm, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                           input int unsigned wait_c, input logic hang, input logic ferr,
                           input int unsigned delay, input logic pause_c1,
                           input logic [31:0] exp_rdata, input logic exp_err, input int unsigned exp_pen);
        int unsigned pen     = 0;
        int unsigned guard   = 0;
        logic        addr_ok = 1'b1;
        logic        ack_ok  = 1'b1;
        logic        hold_ok = 1'b1;
        cur_wait = wait_c; slv_hang = hang; slv_force_err = ferr;
        req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb; req_prot = prot;
        req_valid = 1'b1; rsp_ready = 1'b0;
        #1;
        check({nm, "_ready"}, 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (pause_c1) pause_req = 1'b1;
        check({nm, "_setup"}, 128'({apb.psel, apb.penable}), 128'(2'b10));
        check({nm, "_bus"}, 128'({apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb, apb.pprot}),
              128'({addr, wr, wr ? wdata : 32'h0, wr ? strb : 4'h0, prot}));
        if (pause_ack) ack_ok = 1'b0;
        @(posedge clk); #1;
        while (apb.psel && guard < 40) begin
            if (apb.penable) pen++;
            if (apb.paddr !== addr) addr_ok = 1'b0;
            if (pause_ack) ack_ok = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        check({nm, "_penable_cycles"}, 128'(pen), 128'(exp_pen));
        check({nm, "_paddr_stable"}, 128'(addr_ok), 128'(1));
        for (int d = 0; d < int'(delay); d++) begin
            if (!(rsp_valid && rsp_rdata === exp_rdata && rsp_err === exp_err)) hold_ok = 1'b0;
            if (pause_ack || apb.psel) ack_ok = 1'b0;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        check({nm, "_rsp"}, 128'({rsp_valid, rsp_rdata, rsp_err}), 128'({1'b1, exp_rdata, exp_err}));
        if (pause_ack) ack_ok = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({nm, "_rsp_drop"}, 128'({rsp_valid, pause_ack, apb.psel}), 128'(0));
        check({nm, "_rsp_hold"}, 128'(hold_ok), 128'(1));
        check({nm, "_no_ack_busy"}, 128'(ack_ok), 128'(1));
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int unsigned wait_c;
        logic        hang;
        logic        ferr;
        int unsigned delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int unsigned exp_pen;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] model_mem [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  idx;
        logic        wr, is_err;
        logic [31:0] addr, wdata, exp_rdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int unsigned wt, dly;

        //          wr    addr          wdata         strb  prot  wait hang  ferr  dly  exp_rdata     err   pen
        vecs[0] = '{1'b1, 32'h04, 32'hA5A5_0F0F, 4'hF, 3'd0, 0, 1'b0, 1'b0, 0, 32'h0,         1'b0, 1};
        vecs[1] = '{1'b0, 32'h00, 32'h0,         4'h0, 3'd1, 3, 1'b0, 1'b0, 1, 32'h1234_5678, 1'b0, 4};
        vecs[2] = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'd2, 0, 1'b0, 1'b1, 0, 32'h0,         1'b1, 1};
        vecs[3] = '{1'b0, 32'h04, 32'h0,         4'h0, 3'd3, 0, 1'b0, 1'b0, 2, 32'hA5A5_0F0F, 1'b0, 1};
        vecs[4] = '{1'b1, 32'h04, 32'h1122_3344, 4'h5, 3'd4, 2, 1'b0, 1'b0, 0, 32'h0,         1'b0, 3};
        vecs[5] = '{1'b0, 32'h04, 32'h0,         4'h0, 3'd5, 1, 1'b0, 1'b0, 0, 32'hA522_0F44, 1'b0, 2};
        vecs[6] = '{1'b0, 32'h08, 32'h0,         4'h0, 3'd6, 0, 1'b1, 1'b0, 1, 32'h0,         1'b1, TO};
        vecs[7] = '{1'b0, 32'hC0, 32'h0,         4'h0, 3'd7, 0, 1'b0, 1'b0, 0, 32'h0,         1'b1, 1};
        vecs[8] = '{1'b0, 32'h00, 32'h0,         4'h0, 3'd0, TO-1, 1'b0, 1'b0, 0, 32'h1234_5678, 1'b0, TO};

        rst = 1'b1; pause_req = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
        cur_wait = 0; slv_hang = 1'b0; slv_force_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 128'(0));
        rst = 1'b0;
        #1;
        check("reset_release_ready", 128'({req_ready, pause_ack, rsp_valid}), 128'(3'b100));

        for (int i = 0; i < 9; i++)
            do_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                    vecs[i].prot, vecs[i].wait_c, vecs[i].hang, vecs[i].ferr, vecs[i].delay, 1'b0,
                    vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_pen);

        // Pause raised while a read is in flight: transfer and response drain first.
        do_xfer("pause_rd", 1'b0, 32'h08, 32'h0, 4'h0, 3'd1, 2, 1'b0, 1'b0, 2, 1'b1,
                32'h0BAD_0002, 1'b0, 3);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        #1;
        check("pause_beats_valid", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        check("pause_ack_rise", 128'({pause_ack, apb.psel, req_ready}), 128'(3'b100));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("pause_hold%0d", k), 128'({pause_ack, apb.psel, req_ready}), 128'(3'b100));
        end
        req_valid = 1'b0; pause_req = 1'b0;
        #1;
        check("pause_ack_still", 128'({pause_ack, req_ready}), 128'(2'b10));
        @(posedge clk); #1;
        check("pause_release", 128'({pause_ack, req_ready}), 128'(2'b01));
        do_xfer("post_pause_wr", 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, 3'd0, 1, 1'b0, 1'b0, 0, 1'b0,
                32'h0, 1'b0, 2);

        // Reset during ACCESS abandons the transfer.
        slv_hang = 1'b1; cur_wait = 0; slv_force_err = 1'b0;
        req_write = 1'b0; req_addr = 32'h14; req_prot = 3'd2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_in_access", 128'({apb.psel, apb.penable}), 128'(2'b11));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", all_outputs(), 128'(0));
        rst = 1'b0; slv_hang = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_quiet%0d", k), 128'({rsp_valid, apb.psel, pause_ack}), 128'(0));
        end
        do_xfer("post_rst_rd", 1'b0, 32'h00, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b0, 0, 1'b0,
                32'h1234_5678, 1'b0, 1);

        // Randomized transfers on words 8..15 against a memory model.
        for (int i = 0; i < 16; i++) model_mem[i] = mem_init(i);
        for (int i = 0; i < 40; i++) begin
            idx    = 4'(8 + $urandom_range(0, 7));
            is_err = ($urandom_range(0, 7) == 0);
            wr     = 1'($urandom_range(0, 1));
            wdata  = $urandom;
            strb   = 4'($urandom_range(0, 15));
            prot   = 3'($urandom_range(0, 7));
            wt     = $urandom_range(0, 5);
            dly    = $urandom_range(0, 3);
            addr   = {24'h0, is_err ? 2'b11 : 2'b00, idx, 2'b00};
            if (is_err || wr) exp_rdata = 32'h0;
            else exp_rdata = model_mem[idx];
            if (wr && !is_err)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            do_xfer($sformatf("rnd%0d", i), wr, addr, wdata, strb, prot, wt, 1'b0, 1'b0, dly, 1'b0,
                    exp_rdata, is_err, wt + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
